// File: rtl/score_display.sv
// Score display: double-dabble binary-to-BCD converter feeding a 4-digit multiplexed
// common-anode seven-segment display. Optional leading-zero blanking via LEADING_ZERO_BLANK_EN.
module score_display #(
  parameter int REFRESH_BITS = 18,
  parameter int SAT_VALUE    = 9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] score,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [15:0] bcd,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    LOAD    = 2'd2
  } state_t;

  localparam logic [15:0] SAT_L = 16'(SAT_VALUE);
  localparam logic [REFRESH_BITS-1:0] CNT_ONE = {{(REFRESH_BITS-1){1'b0}}, 1'b1};

  state_t                  state_r, state_s;
  logic [15:0]             last_score_r, last_score_s;
  logic [35:0]             shift_r, shift_s;
  logic [4:0]              bit_cnt_r, bit_cnt_s;
  logic [15:0]             bcd_r, bcd_s;
  logic                    busy_r, busy_s;
  logic [REFRESH_BITS-1:0] cnt_r;
  logic [1:0]              sel_s;
  logic [3:0]              nib_s;
  logic [3:0]              an_r, an_s;
  logic [6:0]              seg_r, seg_s;
  logic                    dp_r;
  logic                    blank_s;

  // One double-dabble step: bias the five BCD nibbles, then shift the whole register left.
  function automatic logic [35:0] dabble_step(input logic [35:0] v);
    logic [35:0] t;
    t = v;
    for (int i = 0; i < 5; i++) begin
      if (t[16+4*i +: 4] >= 4'd5) begin
        t[16+4*i +: 4] = t[16+4*i +: 4] + 4'd3;
      end else begin
        t[16+4*i +: 4] = t[16+4*i +: 4];
      end
    end
    return {t[34:0], 1'b0};
  endfunction

  // Active-low gfedcba pattern for one BCD digit; non-decimal nibbles stay dark.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Converter state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Converter next-state and datapath; score edits while busy are picked up on return to IDLE.
  always_comb begin
    state_s      = state_r;
    last_score_s = last_score_r;
    shift_s      = shift_r;
    bit_cnt_s    = bit_cnt_r;
    bcd_s        = bcd_r;
    busy_s       = busy_r;
    case (state_r)
      IDLE: begin
        if (score != last_score_r) begin
          last_score_s = score;
          shift_s      = {20'd0, score};
          bit_cnt_s    = 5'd0;
          state_s      = CONVERT;
          busy_s       = 1'b1;
        end else begin
          busy_s = 1'b0;
        end
      end
      CONVERT: begin
        shift_s   = dabble_step(shift_r);
        bit_cnt_s = bit_cnt_r + 5'd1;
        busy_s    = 1'b1;
        if (bit_cnt_r == 5'd15) begin
          state_s = LOAD;
        end else begin
          state_s = CONVERT;
        end
      end
      LOAD: begin
        bcd_s   = (last_score_r > SAT_L) ? 16'h9999 : shift_r[31:16];
        state_s = IDLE;
        busy_s  = 1'b0;
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // Converter datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_score_r <= 16'd0;
      shift_r      <= 36'd0;
      bit_cnt_r    <= 5'd0;
      bcd_r        <= 16'h0000;
      busy_r       <= 1'b0;
    end else begin
      last_score_r <= last_score_s;
      shift_r      <= shift_s;
      bit_cnt_r    <= bit_cnt_s;
      bcd_r        <= bcd_s;
      busy_r       <= busy_s;
    end
  end

  assign sel_s = cnt_r[REFRESH_BITS-1 -: 2];

  // Digit select: anode, nibble and leading-zero blanking for the current scan slot.
  always_comb begin
    an_s    = 4'b1111;
    nib_s   = 4'd0;
    blank_s = 1'b0;
    case (sel_s)
      2'd0: begin
        an_s  = 4'b1110;
        nib_s = bcd_r[3:0];
      end
      2'd1: begin
        an_s  = 4'b1101;
        nib_s = bcd_r[7:4];
`ifdef LEADING_ZERO_BLANK_EN
        blank_s = (bcd_r[15:4] == 12'd0);
`else
        blank_s = 1'b0;
`endif
      end
      2'd2: begin
        an_s  = 4'b1011;
        nib_s = bcd_r[11:8];
`ifdef LEADING_ZERO_BLANK_EN
        blank_s = (bcd_r[15:8] == 8'd0);
`else
        blank_s = 1'b0;
`endif
      end
      2'd3: begin
        an_s  = 4'b0111;
        nib_s = bcd_r[15:12];
`ifdef LEADING_ZERO_BLANK_EN
        blank_s = (bcd_r[15:12] == 4'd0);
`else
        blank_s = 1'b0;
`endif
      end
      default: begin
        an_s    = 4'b1111;
        nib_s   = 4'd0;
        blank_s = 1'b0;
      end
    endcase
    if (blank_s) begin
      seg_s = 7'b1111111;
    end else begin
      seg_s = seg_decode(nib_s);
    end
  end

  // Refresh counter and registered display drive.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= '0;
      an_r  <= 4'b1111;
      seg_r <= 7'b1111111;
      dp_r  <= 1'b1;
    end else begin
      cnt_r <= cnt_r + CNT_ONE;
      an_r  <= an_s;
      seg_r <= seg_s;
      dp_r  <= 1'b1;
    end
  end

  assign an   = an_r;
  assign seg  = seg_r;
  assign dp   = dp_r;
  assign bcd  = bcd_r;
  assign busy = busy_r;

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display (REFRESH_BITS=4): arithmetic decimal reference model,
// randomized scores, scan and reset scenarios.
module tb_score_display;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] score = 16'd0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [15:0] bcd;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int         pow10 [4]    = '{1, 10, 100, 1000};
  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  score_display #(.REFRESH_BITS(4), .SAT_VALUE(9999)) dut (
    .clk(clk), .reset(reset), .score(score), .an(an), .seg(seg), .dp(dp), .bcd(bcd), .busy(busy)
  );

  always #5 clk = ~clk;

  // Active edges seen since the last reset release.
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic int shown(input int s);
    return (s > 9999) ? 9999 : s;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_scan(input int v, input int n, input string name);
    int         sel;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      sel     = ((cyc - 1) / 4) % 4;
      exp_an  = ~(4'b0001 << sel);
      exp_seg = seg_tab[(v / pow10[sel]) % 10];
`ifdef LEADING_ZERO_BLANK_EN
      if (sel > 0 && v < pow10[sel]) exp_seg = 7'b1111111;
`endif
      total++;
      if (an !== exp_an || seg !== exp_seg || dp !== 1'b1) begin
        bad++;
        $display("FAIL %s scan cyc=%0d: an=%b seg=%b dp=%b expected an=%b seg=%b dp=1",
                 name, cyc, an, seg, dp, exp_an, exp_seg);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    score = 16'd0;
    repeat (3) @(negedge clk);
    total++;
    if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1 || bcd !== 16'h0000 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: an=%b seg=%b dp=%b bcd=%h busy=%b expected 1111/1111111/1/0000/0",
               an, seg, dp, bcd, busy);
    end
    reset = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if (busy !== 1'b0 || bcd !== 16'h0000) begin
      bad++;
      $display("FAIL zero_no_conv: busy=%b bcd=%h expected 0/0000", busy, bcd);
    end
  endtask

  task automatic test_convert_1234;
    int busy_cycles = 0;
    score = 16'd1234;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      else if (busy_cycles > 0) break;
    end
    total++;
    if (busy_cycles !== 17) begin
      bad++;
      $display("FAIL busy_len: got %0d cycles expected 17", busy_cycles);
    end
    total++;
    if (bcd !== 16'h1234) begin
      bad++;
      $display("FAIL conv_1234: bcd=%h expected 1234", bcd);
    end
    @(negedge clk);
    check_scan(1234, 16, "scan_1234");
  endtask

  task automatic test_saturation;
    int vals [4] = '{65535, 10000, 9999, 0};
    bit ok;
    foreach (vals[i]) begin
      score = 16'(vals[i]);
      @(negedge clk);
      wait_idle(ok);
      total++;
      if (!ok || bcd !== to_bcd(shown(vals[i]))) begin
        bad++;
        $display("FAIL sat_%0d: ok=%0d bcd=%h expected %h", vals[i], ok, bcd, to_bcd(shown(vals[i])));
      end
    end
  endtask

  task automatic test_back_to_back;
    bit seen7 = 1'b0, seen8 = 1'b0, order_ok = 1'b1;
    score = 16'd7;
    @(negedge clk);
    @(negedge clk);
    score = 16'd8;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bcd === 16'h0007) begin
        if (seen8) order_ok = 1'b0;
        seen7 = 1'b1;
      end else if (bcd === 16'h0008) begin
        if (!seen7) order_ok = 1'b0;
        seen8 = 1'b1;
      end else if (bcd !== 16'h0000 || seen7) begin
        order_ok = 1'b0;
      end
    end
    total++;
    if (!seen7 || !order_ok) begin
      bad++;
      $display("FAIL b2b_sequence: seen7=%0d seen8=%0d order_ok=%0d expected 1/1/1", seen7, seen8, order_ok);
    end
    total++;
    if (bcd !== 16'h0008 || busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_final: bcd=%h busy=%b expected 0008/0", bcd, busy);
    end
  endtask

  task automatic test_blank_42;
    bit ok;
    score = 16'd42;
    @(negedge clk);
    wait_idle(ok);
    total++;
    if (!ok || bcd !== 16'h0042) begin
      bad++;
      $display("FAIL conv_42: ok=%0d bcd=%h expected 0042", ok, bcd);
    end
    @(negedge clk);
    check_scan(42, 16, "scan_42");
  endtask

  task automatic test_free_scan;
    check_scan(42, 64, "free_scan");
  endtask

  task automatic test_random;
    bit ok;
    int s;
    for (int t = 0; t < 20; t++) begin
      s = (t % 2 == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 12000));
      score = 16'(s);
      @(negedge clk);
      wait_idle(ok);
      total++;
      if (!ok || bcd !== to_bcd(shown(s))) begin
        bad++;
        $display("FAIL rand_%0d score=%0d: ok=%0d bcd=%h expected %h", t, s, ok, bcd, to_bcd(shown(s)));
      end
      @(negedge clk);
      check_scan(shown(s), 16, "rand_scan");
    end
  endtask

  task automatic test_reset_mid;
    score = 16'd500;
    @(negedge clk);
    repeat (5) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    total++;
    if (an !== 4'b1111 || seg !== 7'b1111111 || bcd !== 16'h0000 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: an=%b seg=%b bcd=%h busy=%b expected 1111/1111111/0000/0", an, seg, bcd, busy);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (17) @(negedge clk);
    total++;
    if (bcd !== 16'h0000 || busy !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_early: bcd=%h busy=%b expected 0000/1", bcd, busy);
    end
    @(negedge clk);
    total++;
    if (bcd !== 16'h0500 || busy !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_500: bcd=%h busy=%b expected 0500/0", bcd, busy);
    end
    @(negedge clk);
    check_scan(500, 16, "scan_500");
  endtask

  initial begin
    test_reset();
    test_convert_1234();
    test_saturation();
    test_back_to_back();
    test_blank_42();
    test_free_scan();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
